// File: rtl/spart_driver_if.sv
`timescale 1ns/1ps
// Purpose: control/handshake signals between the SPART bus master and the SPART.
// Latency: none, wires only.
// Backpressure: rda/tbr are the SPART's ready/valid; the tristate databus stays a plain inout on the driver.
// Ports: rda, tbr (SPART -> master); iocs, iorw, ioaddr (master -> SPART).
interface spart_driver_if;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  modport master (input rda, input tbr, output iocs, output iorw, output ioaddr);
  modport slave  (output rda, output tbr, input iocs, input iorw, input ioaddr);
endinterface

// File: rtl/spart_driver.sv
`timescale 1ns/1ps
// Purpose: loads the SPART baud divisor selected by br_cfg, then echoes every received character.
// Latency: READ one cycle after rda seen in IDLE; WRITE two cycles after READ when tbr is already high.
// Backpressure: waits on tbr up to TBR_TIMEOUT cycles, then drops the character and sets a sticky error.
// Ports: clk, rst (async, active-high); br_cfg (async switches); bus (rda/tbr in, iocs/iorw/ioaddr out);
//        databus (shared 8-bit tristate); echo_count (wrapping); tbr_timeout_err (sticky).
module spart_driver #(
  parameter logic [15:0] DIV_0       = 16'd20832,
  parameter logic [15:0] DIV_1       = 16'd10415,
  parameter logic [15:0] DIV_2       = 16'd5207,
  parameter logic [15:0] DIV_3       = 16'd2603,
  parameter logic [19:0] TBR_TIMEOUT = 20'd1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            br_cfg,
  spart_driver_if.master        bus,
  inout  wire  [7:0]            databus,
  output logic [7:0]            echo_count,
  output logic                  tbr_timeout_err
);

  typedef enum logic [2:0] {INIT, CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR, WRITE} state_t;

  state_t      state, state_nxt;
  logic        init_done;
  logic [1:0]  br_cfg_m, br_cfg_s, cfg_cur;
  logic        pending;
  logic [7:0]  char_reg;
  logic [19:0] timer;
  logic        io_cs, io_rw;
  logic [1:0]  io_addr;
  logic [7:0]  dout;
  logic [15:0] div_new, div_cur;
  logic        cfg_changed;
  logic        in_echo;
  logic        tbr_expired;

  function automatic logic [15:0] div_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_0;
      2'b01:   return DIV_1;
      2'b10:   return DIV_2;
      default: return DIV_3;
    endcase
  endfunction

  // Low byte uses the freshly synchronized switches (cfg_cur is only latched
  // at the end of CFG_LO); high byte uses the latched copy so both halves match.
  assign div_new     = div_sel(br_cfg_s);
  assign div_cur     = div_sel(cfg_cur);
  assign cfg_changed = (br_cfg_s != cfg_cur);
  assign in_echo     = (state == READ) || (state == WAIT_TBR) || (state == WRITE);
  assign tbr_expired = (timer == TBR_TIMEOUT - 20'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    io_cs     = 1'b0;
    io_rw     = 1'b1;
    io_addr   = 2'b01;
    dout      = 8'h00;
    case (state)
      INIT:     if (init_done) state_nxt = CFG_LO;
      CFG_LO: begin
        io_cs = 1'b1; io_rw = 1'b0; io_addr = 2'b10; dout = div_new[7:0];
        state_nxt = CFG_HI;
      end
      CFG_HI: begin
        io_cs = 1'b1; io_rw = 1'b0; io_addr = 2'b11; dout = div_cur[15:8];
        state_nxt = IDLE;
      end
      // Reconfiguration wins over a waiting character.
      IDLE: begin
        if (pending || cfg_changed) state_nxt = CFG_LO;
        else if (bus.rda)           state_nxt = READ;
      end
      READ: begin
        io_cs = 1'b1; io_rw = 1'b1; io_addr = 2'b00;
        state_nxt = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (bus.tbr)          state_nxt = WRITE;
        else if (tbr_expired) state_nxt = IDLE;
      end
      WRITE: begin
        io_cs = 1'b1; io_rw = 1'b0; io_addr = 2'b00; dout = char_reg;
        state_nxt = IDLE;
      end
      default:  state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done       <= 1'b0;
      br_cfg_m        <= 2'b00;
      br_cfg_s        <= 2'b00;
      cfg_cur         <= 2'b00;
      pending         <= 1'b0;
      char_reg        <= 8'h00;
      timer           <= 20'd0;
      echo_count      <= 8'h00;
      tbr_timeout_err <= 1'b0;
    end else begin
      br_cfg_m <= br_cfg;
      br_cfg_s <= br_cfg_m;
      if (state == INIT)   init_done <= 1'b1;
      if (state == CFG_LO) cfg_cur   <= br_cfg_s;
      if (state == READ)   char_reg  <= databus;
      if (state == WAIT_TBR) timer <= timer + 20'd1;
      else                   timer <= 20'd0;
      if (state == WAIT_TBR && !bus.tbr && tbr_expired) tbr_timeout_err <= 1'b1;
      if (state == WRITE) echo_count <= echo_count + 8'd1;
      // A switch change mid-echo is remembered so the echo finishes on the old divisor.
      if (state == IDLE && (pending || cfg_changed)) pending <= 1'b0;
      else if (in_echo && cfg_changed)               pending <= 1'b1;
    end
  end

  assign bus.iocs   = io_cs;
  assign bus.iorw   = io_rw;
  assign bus.ioaddr = io_addr;
  assign databus    = (io_cs && !io_rw) ? dout : 8'bz;

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
Bus-master controller that configures and sequences the SPART (receive buffer, transmit buffer, baud divisor) over the shared iocs/iorw/ioaddr/databus interface. After reset it loads the 16-bit baud divisor selected by the br_cfg switches. It then runs an echo loop: wait for a received character, read it, wait for transmit-buffer-ready, and write it back. It reloads the divisor whenever br_cfg changes and sits between the board switches and the SPART instance in the top level.

Parameters:
DIV_0, 16'd20832, divisor for br_cfg=00 (4800 baud @100 MHz, clk/baud-1)
DIV_1, 16'd10415, divisor for br_cfg=01 (9600)
DIV_2, 16'd5207, divisor for br_cfg=10 (19200)
DIV_3, 16'd2603, divisor for br_cfg=11 (38400)
TBR_TIMEOUT, 20'd1000000, cycles to wait for tbr before dropping a character

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
br_cfg  input  2  baud select switches, asynchronous to clk
rda  input  1  SPART receive data available
tbr  input  1  SPART transmit buffer ready
iocs  output  1  SPART chip select
iorw  output  1  1=read, 0=write
ioaddr  output  2  00 rx/tx buffer, 01 status, 10 divisor low, 11 divisor high
databus  inout  8  shared SPART data bus
echo_count  output  8  characters echoed, wraps 255->0
tbr_timeout_err  output  1  sticky; set when a character is dropped on timeout

Behaviour:
- One clock; reset is asynchronous and active-high. The clock port is named clk and the reset port is named rst.
- Reset values: state=INIT, iocs=0, iorw=1, ioaddr=01, databus=Z, echo_count=0, tbr_timeout_err=0, sync flops=00, cfg_cur=00, pending=0.
- Idle bus: iocs=0, iorw=1, ioaddr=01. Never present ioaddr=00 with iorw=1 outside READ. The receive buffer drives the bus and clears rda on that combination regardless of iocs.
- databus is driven only when iocs=1 and iorw=0; otherwise it is high-Z.
- br_cfg passes through a 2-flop synchronizer to give br_cfg_s.
- FSM states and transitions:
  INIT: holds 2 cycles (synchronizer fill), then goes to CFG_LO.
  CFG_LO: 1 cycle. Latches cfg_cur<=br_cfg_s; drives iocs=1, iorw=0, ioaddr=10, databus=DIV[cfg][7:0]. The divisor is selected from br_cfg_s in this same cycle. Goes to CFG_HI.
  CFG_HI: 1 cycle. Drives iocs=1, iorw=0, ioaddr=11, databus=DIV[cfg_cur][15:8]. Goes to IDLE.
  IDLE: if pending or br_cfg_s!=cfg_cur, clears pending and goes to CFG_LO. Else if rda=1, goes to READ. Reconfiguration has priority over rda when both occur in the same cycle.
  READ: 1 cycle. Drives iocs=1, iorw=1, ioaddr=00 and captures databus into char_reg at the clock edge. Goes to WAIT_TBR with the timer cleared.
  WAIT_TBR: if tbr=1, goes to WRITE. If the timer reaches TBR_TIMEOUT-1 with tbr=0, sets tbr_timeout_err and returns to IDLE; the character is dropped.
  WRITE: 1 cycle. Drives iocs=1, iorw=0, ioaddr=00, databus=char_reg; echo_count increments. Goes to IDLE.
- A br_cfg_s change during READ, WAIT_TBR or WRITE sets pending. The in-flight echo completes with the old divisor; reconfiguration happens on the next IDLE.
- Latency: from rda rising in IDLE, READ occurs on the next cycle. With tbr already high, WRITE occurs 2 cycles after READ.
- tbr_timeout_err clears only on reset.
- Reset asserted mid-operation immediately tri-states databus, forces idle bus values and returns to INIT.

Test Plan:
- Reset release with br_cfg=01 -> after INIT (2 cycles): one cycle ioaddr=10 databus=8'h AF, next cycle ioaddr=11 databus=8'h28, then idle bus (ioaddr=01, iorw=1, iocs=0).
- Echo: model presents 8'h5A and raises rda, tbr=1 -> READ cycle captures 5A; WRITE drives 8'h5A with ioaddr=00, iorw=0 two cycles later; echo_count=1; databus Z otherwise.
- br_cfg 01->11 while in WAIT_TBR, tbr delayed 10 cycles -> WRITE completes first, then CFG_LO/CFG_HI write 8'h2B/8'h0A; rda asserted in that same IDLE cycle is serviced afterward.
- tbr held 0 with TBR_TIMEOUT=16 -> 16 cycles in WAIT_TBR, tbr_timeout_err=1, no WRITE, echo_count unchanged; next character still echoes.
- 256 echoes -> echo_count wraps to 0.
- Reset asserted during WAIT_TBR -> outputs return to reset values asynchronously; full divisor load repeats after release.
